// File: rtl/dbus_pkg.sv
// Shared definitions for the data-side memory / MMIO subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_pkg;

   // MMIO byte offsets within the I/O region (Daddr[4:0], low two bits zero)
   localparam logic [4:0] OFF_LED    = 5'h00;
   localparam logic [4:0] OFF_SW     = 5'h04;
   localparam logic [4:0] OFF_TCNT   = 5'h08;
   localparam logic [4:0] OFF_TCMP   = 5'h0C;
   localparam logic [4:0] OFF_TXDATA = 5'h10;
   localparam logic [4:0] OFF_STATUS = 5'h14;

   // STATUS register bit positions
   localparam int STAT_BUSY   = 0;
   localparam int STAT_TMATCH = 1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // One-hot write strobes produced by the address decoder
   typedef struct packed {
      logic ram;
      logic led;
      logic tcnt;
      logic tcmp;
      logic txdata;
      logic status;
   } wr_sel_t;

   // Rebuild the byte offset of an MMIO register from its word index
   function automatic logic [4:0] mmio_off(input logic [2:0] word_idx);
      return {word_idx, 2'b00};
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Latency: Txd falls on the edge that accepts start; frame is 10*CLK_DIV cycles.
// Backpressure: start is ignored while busy; the caller must poll busy.
module uart_tx
   import dbus_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       Clk,
   input  logic       Clrn,
   input  logic       start,
   input  logic [7:0] data,
   output logic       Txd,
   output logic       busy
);

   localparam int             CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

   tx_state_t     state, state_nxt;
   logic [CW-1:0] div_cnt, div_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          bit_end;

   assign bit_end = (div_cnt == DIV_LAST);

   // State, bit-period counter, bit index and shift register
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state   <= TX_IDLE;
         div_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         bit_idx <= bit_nxt;
         shift   <= shift_nxt;
      end
   end

   // Next-state logic; Txd decoded from state so reset forces it high at once
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      Txd       = 1'b1;
      busy      = 1'b1;
      case (state)
         TX_IDLE: begin
            busy    = 1'b0;
            div_nxt = '0;
            bit_nxt = '0;
            if (start) begin
               state_nxt = TX_START;
               shift_nxt = data;
            end
         end
         TX_START: begin
            Txd = 1'b0;
            if (bit_end) begin
               state_nxt = TX_DATA;
               div_nxt   = '0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            Txd = shift[0];
            if (bit_end) begin
               div_nxt   = '0;
               shift_nxt = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_nxt = TX_STOP;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               state_nxt = TX_IDLE;
               div_nxt   = '0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/dbus_mmio.sv
// CPU data port: word RAM plus MMIO (LED, switches, timer, UART TX).
// Latency: reads combinational from Daddr; writes take effect at the Wmem edge.
// Backpressure: none; TXDATA writes while the UART is busy are dropped.
module dbus_mmio
   import dbus_pkg::*;
#(
   parameter int RAM_AW  = 6,
   parameter int CLK_DIV = 16
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic [31:0] Daddr,
   input  logic [31:0] Dwrite,
   input  logic        Wmem,
   output logic [31:0] Dread,
   input  logic [15:0] Sw,
   output logic [15:0] Led,
   output logic        Txd
);

   localparam int RAM_WORDS = 2 ** RAM_AW;

   logic [31:0]       ram [RAM_WORDS];
   logic              sel_mmio;
   logic [RAM_AW-1:0] ram_idx;
   logic [4:0]        off;
   wr_sel_t           wr;

   logic [15:0] sw_meta, sw_sync;
   logic [31:0] tcnt, tcmp;
   logic        tmatch;
   logic        tx_busy;

   // Address bits that neither region decodes (aliasing is intentional)
   logic unused_addr_bits;
   assign unused_addr_bits = ^{Daddr[30:RAM_AW+2], Daddr[1:0]};

   assign sel_mmio = Daddr[31];
   assign ram_idx  = Daddr[RAM_AW+1:2];
   assign off      = mmio_off(Daddr[4:2]);

   // Write decode: one strobe per writable target
   always_comb begin
      wr = '0;
      if (Wmem) begin
         if (!sel_mmio) begin
            wr.ram = 1'b1;
         end else begin
            case (off)
               OFF_LED:    wr.led    = 1'b1;
               OFF_TCNT:   wr.tcnt   = 1'b1;
               OFF_TCMP:   wr.tcmp   = 1'b1;
               OFF_TXDATA: wr.txdata = 1'b1;
               OFF_STATUS: wr.status = 1'b1;
               default:    ;
            endcase
         end
      end
   end

   // Data RAM; contents deliberately left unreset
   always_ff @(posedge Clk) begin
      if (wr.ram) ram[ram_idx] <= Dwrite;
   end

   // LED register
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn)       Led <= '0;
      else if (wr.led) Led <= Dwrite[15:0];
   end

   // Two-flop synchronizer for the asynchronous switch inputs
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= Sw;
         sw_sync <= sw_meta;
      end
   end

   // Free-running timer, compare value and sticky match (set beats clear)
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         tcnt   <= '0;
         tcmp   <= '1;
         tmatch <= 1'b0;
      end else begin
         tcnt   <= wr.tcnt ? Dwrite : tcnt + 32'd1;
         if (wr.tcmp) tcmp <= Dwrite;
         tmatch <= (tcnt == tcmp) | (tmatch & ~(wr.status & Dwrite[STAT_TMATCH]));
      end
   end

   uart_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .Clk   (Clk),
      .Clrn  (Clrn),
      .start (wr.txdata),
      .data  (Dwrite[7:0]),
      .Txd   (Txd),
      .busy  (tx_busy)
   );

   // Read mux; reflects pre-edge state so a same-cycle write reads old data
   always_comb begin
      Dread = '0;
      if (!sel_mmio) begin
         Dread = ram[ram_idx];
      end else begin
         case (off)
            OFF_LED:  Dread = {16'h0, Led};
            OFF_SW:   Dread = {16'h0, sw_sync};
            OFF_TCNT: Dread = tcnt;
            OFF_TCMP: Dread = tcmp;
            OFF_STATUS: begin
               Dread[STAT_BUSY]   = tx_busy;
               Dread[STAT_TMATCH] = tmatch;
            end
            default:  Dread = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_mmio.sv
// Bench for dbus_mmio: directed vectors, corner sequences and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_dbus_mmio;

   localparam int CD = 4;
   localparam int AW = 6;
   localparam logic [31:0] A_LED  = 32'h8000_0000;
   localparam logic [31:0] A_SW   = 32'h8000_0004;
   localparam logic [31:0] A_TCNT = 32'h8000_0008;
   localparam logic [31:0] A_TCMP = 32'h8000_000C;
   localparam logic [31:0] A_TX   = 32'h8000_0010;
   localparam logic [31:0] A_STAT = 32'h8000_0014;

   logic        Clk, Clrn, Wmem, Txd;
   logic [31:0] Daddr, Dwrite, Dread;
   logic [15:0] Sw, Led;

   int tests = 0;
   int fails = 0;

   dbus_mmio #(.RAM_AW(AW), .CLK_DIV(CD)) dut (
      .Clk(Clk), .Clrn(Clrn), .Daddr(Daddr), .Dwrite(Dwrite), .Wmem(Wmem),
      .Dread(Dread), .Sw(Sw), .Led(Led), .Txd(Txd)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model state
   logic [31:0] m_mem [64];
   logic [15:0] m_led;
   logic [31:0] m_tcnt, m_tcmp;
   logic        m_tmatch;
   int          m_tx_left;
   logic [7:0]  m_tx_byte;
   logic [15:0] sw_seen [$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wmem;
      logic [31:0] exp;
   } vec_t;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_led = '0; m_tcnt = '0; m_tcmp = '1; m_tmatch = 1'b0; m_tx_left = 0;
      sw_seen.delete();
   endfunction

   function automatic logic [15:0] sw_exp();
      return (sw_seen.size() < 2) ? 16'h0 : sw_seen[0];
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (!a[31]) return m_mem[a[AW+1:2]];
      case (a[4:2])
         3'd0: r = {16'h0, m_led};
         3'd1: r = {16'h0, sw_exp()};
         3'd2: r = m_tcnt;
         3'd3: r = m_tcmp;
         3'd5: r = {30'h0, m_tmatch, (m_tx_left != 0)};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Serial line level from elapsed frame time: bit 0 start, 1..8 data, 9 stop
   function automatic logic model_txd();
      int b;
      if (m_tx_left == 0) return 1'b1;
      b = (10 * CD - m_tx_left) / CD;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return m_tx_byte[b-1];
   endfunction

   function automatic void model_step(logic [31:0] a, logic [31:0] wd, logic wm);
      bit hit, clr, twr, tstart;
      logic [31:0] new_tcmp;
      hit = (m_tcnt == m_tcmp);
      clr = 0; twr = 0; tstart = 0; new_tcmp = m_tcmp;
      if (wm) begin
         if (!a[31]) m_mem[a[AW+1:2]] = wd;
         else case (a[4:2])
            3'd0: m_led = wd[15:0];
            3'd2: twr = 1;
            3'd3: new_tcmp = wd;
            3'd4: tstart = 1;
            3'd5: clr = wd[1];
            default: ;
         endcase
      end
      m_tmatch = hit | (m_tmatch & !clr);
      m_tcnt   = twr ? wd : m_tcnt + 32'd1;
      m_tcmp   = new_tcmp;
      if (m_tx_left != 0) m_tx_left--;
      else if (tstart) begin
         m_tx_left = 10 * CD;
         m_tx_byte = wd[7:0];
      end
      sw_seen.push_back(Sw);
      if (sw_seen.size() > 2) void'(sw_seen.pop_front());
   endfunction

   task automatic tick(input logic [31:0] a, input logic [31:0] wd, input logic wm,
                       input bit chk, output logic [31:0] rd);
      Daddr = a; Dwrite = wd; Wmem = wm;
      #2;
      rd = Dread;
      if (chk) begin
         check("dread", Dread, model_read(a));
         check("led", {16'h0, Led}, {16'h0, m_led});
         check("txd", {31'h0, Txd}, {31'h0, model_txd()});
      end
      @(posedge Clk);
      model_step(a, wd, wm);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      vec_t vt [16];

      vt[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1000_0004};
      vt[1]  = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vt[2]  = '{32'h0000_0110, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vt[3]  = '{32'h0000_0014, 32'h0,         1'b0, 32'h1000_0005};
      vt[4]  = '{32'h7FFF_FF12, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vt[5]  = '{A_LED,         32'h0001_A5A5, 1'b1, 32'h0};
      vt[6]  = '{A_LED,         32'h0,         1'b0, 32'h0000_A5A5};
      vt[7]  = '{32'hFFFF_FFE0, 32'h0,         1'b0, 32'h0000_A5A5};
      vt[8]  = '{32'h8000_0018, 32'h1234_5678, 1'b1, 32'h0};
      vt[9]  = '{32'h8000_0018, 32'h0,         1'b0, 32'h0};
      vt[10] = '{32'h8000_001C, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vt[11] = '{32'h8000_001C, 32'h0,         1'b0, 32'h0};
      vt[12] = '{A_TX,          32'h0,         1'b0, 32'h0};
      vt[13] = '{A_TCMP,        32'h0,         1'b0, 32'hFFFF_FFFF};
      vt[14] = '{A_LED,         32'h0,         1'b0, 32'h0000_A5A5};
      vt[15] = '{A_STAT,        32'h0,         1'b0, 32'h0};

      // Reset state
      Clrn = 1'b0; Daddr = A_TCMP; Dwrite = '0; Wmem = 1'b0; Sw = '0;
      #12;
      check("rst_led", {16'h0, Led}, 32'h0);
      check("rst_txd", {31'h0, Txd}, 32'h1);
      check("rst_tcmp", Dread, 32'hFFFF_FFFF);
      Daddr = A_STAT; #1;
      check("rst_status", Dread, 32'h0);
      Daddr = A_TCNT; #1;
      check("rst_tcnt", Dread, 32'h0);
      @(negedge Clk);
      Clrn = 1'b1;
      model_reset();

      for (int i = 0; i < 64; i++) tick(32'(i) << 2, 32'h1000_0000 + 32'(i), 1'b1, 1'b0, rd);

      // Directed vectors
      for (int i = 0; i < 16; i++) begin
         tick(vt[i].addr, vt[i].wdata, vt[i].wmem, 1'b1, rd);
         check($sformatf("vec%0d", i), rd, vt[i].exp);
      end
      check("led_pin", {16'h0, Led}, 32'h0000_A5A5);

      // Switch synchronizer: visible after the second edge
      Sw = 16'h1234;
      tick(A_SW, 0, 1'b0, 1'b1, rd); check("sw_e0", rd, 32'h0);
      tick(A_SW, 0, 1'b0, 1'b1, rd); check("sw_e1", rd, 32'h0);
      tick(A_SW, 0, 1'b0, 1'b1, rd); check("sw_e2", rd, 32'h0000_1234);

      // Timer wrap and compare
      tick(A_TCNT, 32'hFFFF_FFFE, 1'b1, 1'b1, rd);
      tick(A_TCMP, 32'h0000_0001, 1'b1, 1'b1, rd);
      tick(A_TCNT, 0, 1'b0, 1'b1, rd); check("tcnt_max", rd, 32'hFFFF_FFFF);
      tick(A_TCNT, 0, 1'b0, 1'b1, rd); check("tcnt_wrap", rd, 32'h0);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("tmatch_pre", rd, 32'h0);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("tmatch_set", rd, 32'h2);
      tick(A_STAT, 2, 1'b1, 1'b1, rd);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("tmatch_clr", rd, 32'h0);

      // Set and clear of tmatch in the same cycle: set wins
      tick(A_TCMP, 32'h102, 1'b1, 1'b1, rd);
      tick(A_TCNT, 32'h100, 1'b1, 1'b1, rd);
      tick(A_STAT, 0, 1'b0, 1'b1, rd);
      tick(A_STAT, 0, 1'b0, 1'b1, rd);
      tick(A_STAT, 2, 1'b1, 1'b1, rd);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("set_wins", rd, 32'h2);
      tick(A_STAT, 2, 1'b1, 1'b1, rd);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("set_wins_clr", rd, 32'h0);

      // UART frame 0x55 with a dropped mid-frame write
      tick(A_TX, 32'h55, 1'b1, 1'b1, rd);
      for (int c = 0; c < 40; c++) begin
         check("tx55_txd", {31'h0, Txd}, 32'((c / 4) % 2));
         if (c == 10) tick(A_TX, 32'hFF, 1'b1, 1'b1, rd);
         else begin
            tick(A_STAT, 0, 1'b0, 1'b1, rd);
            check("tx55_busy", {31'h0, rd[0]}, 32'h1);
         end
      end
      check("tx55_idle", {31'h0, Txd}, 32'h1);
      Daddr = A_STAT; Wmem = 1'b0; #1;
      check("tx55_done", Dread, 32'h0);

      // New frame accepted in first idle cycle, then reset mid-DATA
      tick(A_TX, 32'h00, 1'b1, 1'b1, rd);
      for (int c = 0; c < 8; c++) begin
         tick(A_STAT, 0, 1'b0, 1'b1, rd);
         check("f0_busy", {31'h0, rd[0]}, 32'h1);
      end
      check("pre_rst_txd", {31'h0, Txd}, 32'h0);
      Daddr = A_STAT; Wmem = 1'b0; #1;
      Clrn = 1'b0; #1;
      check("mid_rst_txd", {31'h0, Txd}, 32'h1);
      check("mid_rst_led", {16'h0, Led}, 32'h0);
      check("mid_rst_busy", Dread, 32'h0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Clrn = 1'b1;
      model_reset();

      tick(A_TX, 32'h00, 1'b1, 1'b1, rd);
      for (int c = 0; c < 40; c++) begin
         check("f2_txd", {31'h0, Txd}, (c < 36) ? 32'h0 : 32'h1);
         tick(A_STAT, 0, 1'b0, 1'b1, rd);
         check("f2_busy", {31'h0, rd[0]}, 32'h1);
      end
      check("f2_idle", {31'h0, Txd}, 32'h1);
      tick(A_STAT, 0, 1'b0, 1'b1, rd); check("f2_done", rd, 32'h0);

      // Random traffic against the reference model
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] a, wd;
         logic        wm;
         a     = $urandom;
         a[31] = ($urandom_range(0, 9) >= 4);
         wd    = $urandom;
         wm    = ($urandom_range(0, 2) == 0);
         if (a[31] && a[4:2] == 3'd3 && $urandom_range(0, 1) == 1)
            wd = m_tcnt + 32'($urandom_range(1, 6));
         if (a[31] && a[4:2] == 3'd2 && $urandom_range(0, 1) == 1)
            wd = m_tcmp - 32'($urandom_range(1, 6));
         if ($urandom_range(0, 7) == 0) Sw = 16'($urandom);
         tick(a, wd, wm, 1'b1, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
